// File: rtl/core88_memctl.sv
// Byte-wide core bus to 16-bit asynchronous SRAM bridge with programmable wait states.
// A single-word read cache lets repeated reads of the same word finish without SRAM wait states.
module core88_memctl #(
    parameter int unsigned WAIT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] address,
    input  logic [7:0]  data,
    input  logic        wreq,
    output logic [7:0]  bus,
    output logic        locked,
    output logic [18:0] sram_a,
    output logic [15:0] sram_dq_o,
    input  logic [15:0] sram_dq_i,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [1:0] {SAMPLE, ACCESS, DONE} state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t      st;
    logic [3:0]  cnt;
    logic [19:0] a_r;
    logic [7:0]  d_r;
    logic        w_r;
    logic        c_valid;
    logic [18:0] c_tag;
    logic [15:0] c_word;

    logic hit_in;
    logic hit_latched;

    assign hit_in      = c_valid && (c_tag == address[19:1]);
    assign hit_latched = c_valid && (c_tag == a_r[19:1]);

    // Enables are registers with async reset so an aborted access releases the SRAM immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st        <= SAMPLE;
            cnt       <= 4'd0;
            a_r       <= 20'd0;
            d_r       <= 8'd0;
            w_r       <= 1'b0;
            c_valid   <= 1'b0;
            c_tag     <= 19'd0;
            c_word    <= 16'd0;
            bus       <= 8'h00;
            locked    <= 1'b0;
            sram_a    <= 19'd0;
            sram_dq_o <= 16'd0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
        end else begin
            case (st)
                SAMPLE: begin
                    a_r <= address;
                    d_r <= data;
                    w_r <= wreq;
                    if (!wreq && hit_in) begin
                        bus    <= address[0] ? c_word[15:8] : c_word[7:0];
                        locked <= 1'b1;
                        st     <= DONE;
                    end else begin
                        sram_a    <= address[19:1];
                        sram_ub_n <= ~address[0];
                        sram_lb_n <= address[0];
                        cnt       <= WAIT_CNT;
                        st        <= ACCESS;
                        if (wreq) begin
                            sram_dq_o <= {data, data};
                            sram_we_n <= 1'b0;
                        end else begin
                            sram_oe_n <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!w_r) begin
                            bus     <= a_r[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];
                            c_word  <= sram_dq_i;
                            c_tag   <= a_r[19:1];
                            c_valid <= 1'b1;
                        end else if (hit_latched) begin
                            // Write-through keeps the cached word coherent with SRAM.
                            if (a_r[0]) begin
                                c_word[15:8] <= d_r;
                            end else begin
                                c_word[7:0] <= d_r;
                            end
                        end
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        locked    <= 1'b1;
                        st        <= DONE;
                    end
                end
                DONE: begin
                    locked <= 1'b0;
                    st     <= SAMPLE;
                end
                default: begin
                    locked <= 1'b0;
                    st     <= SAMPLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core88_memctl.sv
// Directed bench for core88_memctl: a WAIT=2 instance for most cases and a WAIT=0 instance for back-to-back misses.
module tb_core88_memctl;

    logic        clock;
    logic        resetS, resetF;
    logic [19:0] addrS, addrF;
    logic [7:0]  dataS, dataF;
    logic        wreqS, wreqF;
    logic [15:0] sramRd;

    logic [7:0]  busS, busF;
    logic        lockedS, lockedF;
    logic [18:0] sramAS, sramAF;
    logic [15:0] dqOS, dqOF;
    logic        weNS, oeNS, ubNS, lbNS;
    logic        weNF, oeNF, ubNF, lbNF;

    int assertCount = 0;
    int failCount   = 0;

    int bothLowS    = 0;
    int doubleLock  = 0;
    bit prevLockS   = 0;
    bit prevLockF   = 0;
    int lowRunF     = 0;
    int minGapF     = 99;
    bit seenPulseF  = 0;

    core88_memctl #(.WAIT(2)) dutSlow (
        .clock(clock), .reset(resetS), .address(addrS), .data(dataS), .wreq(wreqS),
        .bus(busS), .locked(lockedS), .sram_a(sramAS), .sram_dq_o(dqOS), .sram_dq_i(sramRd),
        .sram_we_n(weNS), .sram_oe_n(oeNS), .sram_ub_n(ubNS), .sram_lb_n(lbNS)
    );

    core88_memctl #(.WAIT(0)) dutFast (
        .clock(clock), .reset(resetF), .address(addrF), .data(dataF), .wreq(wreqF),
        .bus(busF), .locked(lockedF), .sram_a(sramAF), .sram_dq_o(dqOF), .sram_dq_i(sramRd),
        .sram_we_n(weNF), .sram_oe_n(oeNF), .sram_ub_n(ubNF), .sram_lb_n(lbNF)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Protocol watchers: no simultaneous we/oe, no back-to-back locked, and the fast instance's pulse spacing.
    always @(negedge clock) begin
        if (!resetS && !weNS && !oeNS) bothLowS++;
        if (!resetS && lockedS && prevLockS) doubleLock++;
        if (!resetF && lockedF && prevLockF) doubleLock++;
        prevLockS = lockedS;
        prevLockF = lockedF;
        if (!resetF) begin
            if (lockedF) begin
                if (seenPulseF && lowRunF < minGapF) minGapF = lowRunF;
                seenPulseF = 1;
                lowRunF = 0;
            end else begin
                lowRunF++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called at the negedge of a SAMPLE cycle; returns at the negedge of the following SAMPLE cycle.
    task automatic applyStimulus(
        input  bit          fast,
        input  logic [19:0] a,
        input  logic [7:0]  d,
        input  logic        w,
        input  bit          scramble,
        output int          cycles,
        output logic [7:0]  rd,
        output int          weLow,
        output int          oeLow,
        output logic [18:0] aAccess,
        output logic        ubAccess,
        output logic        lbAccess,
        output logic [15:0] dqDone
    );
        bit done;
        if (fast) begin
            addrF = a; dataF = d; wreqF = w;
        end else begin
            addrS = a; dataS = d; wreqS = w;
        end
        cycles = 1; weLow = 0; oeLow = 0; done = 0;
        rd = 8'h00; aAccess = 19'd0; ubAccess = 1'b1; lbAccess = 1'b1; dqDone = 16'd0;
        while (!done && cycles < 40) begin
            @(posedge clock);
            @(negedge clock);
            cycles++;
            if (cycles == 2) begin
                aAccess  = fast ? sramAF : sramAS;
                ubAccess = fast ? ubNF : ubNS;
                lbAccess = fast ? lbNF : lbNS;
                if (scramble && !fast) begin
                    addrS = 20'hFFFFF; dataS = 8'hEE; wreqS = ~w;
                end
            end
            if ((fast ? weNF : weNS) == 1'b0) weLow++;
            if ((fast ? oeNF : oeNS) == 1'b0) oeLow++;
            if (fast ? lockedF : lockedS) begin
                done   = 1;
                rd     = fast ? busF : busS;
                dqDone = fast ? dqOF : dqOS;
            end
        end
        checkOutput("txnCompleted", {31'd0, done}, 32'd1);
        @(posedge clock);
        @(negedge clock);
    endtask

    int          cyc, weL, oeL, lockSeen;
    logic [7:0]  rd;
    logic [18:0] aAcc;
    logic        ubA, lbA;
    logic [15:0] dqD;

    initial begin
        resetS = 1'b1; resetF = 1'b1;
        addrS = 20'd0; dataS = 8'd0; wreqS = 1'b0;
        addrF = 20'd0; dataF = 8'd0; wreqF = 1'b0;
        sramRd = 16'h0000;

        repeat (2) @(negedge clock);
        checkOutput("rstLocked", {31'd0, lockedS}, 32'd0);
        checkOutput("rstBus", {24'd0, busS}, 32'h00);
        checkOutput("rstEnables", {28'd0, weNS, oeNS, ubNS, lbNS}, 32'hF);
        checkOutput("rstSramA", {13'd0, sramAS}, 32'd0);
        checkOutput("rstDqO", {16'd0, dqOS}, 32'd0);

        $display("[TB] reset during a write access");
        resetS = 1'b0;
        addrS = 20'h12345; dataS = 8'h77; wreqS = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput("midAccessWeLow", {31'd0, weNS}, 32'd0);
        resetS = 1'b1;
        #1;
        checkOutput("asyncWeRelease", {29'd0, weNS, ubNS, lbNS}, 32'h7);
        lockSeen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (lockedS) lockSeen++;
        end
        checkOutput("noLockInReset", lockSeen, 0);
        resetS = 1'b0;
        addrS = 20'h00000; wreqS = 1'b0;

        sramRd = 16'hEA5C;
        applyStimulus(0, 20'hFFFF0, 8'h00, 1'b0, 0, cyc, rd, weL, oeL, aAcc, ubA, lbA, dqD);
        checkOutput("postResetBus", {24'd0, rd}, 32'h5C);
        checkOutput("postResetCycles", cyc, 5);
        checkOutput("postResetOeWidth", oeL, 3);

        $display("[TB] read miss then hit in same word");
        sramRd = 16'h3412;
        applyStimulus(0, 20'h00101, 8'h00, 1'b0, 0, cyc, rd, weL, oeL, aAcc, ubA, lbA, dqD);
        checkOutput("missBus", {24'd0, rd}, 32'h34);
        checkOutput("missCycles", cyc, 5);
        checkOutput("missLanes", {30'd0, ubA, lbA}, 32'h1);
        sramRd = 16'h0000;
        applyStimulus(0, 20'h00100, 8'h00, 1'b0, 0, cyc, rd, weL, oeL, aAcc, ubA, lbA, dqD);
        checkOutput("hitBus", {24'd0, rd}, 32'h12);
        checkOutput("hitCycles", cyc, 2);
        checkOutput("hitNoOe", oeL, 0);

        $display("[TB] write-through to cached word");
        applyStimulus(0, 20'h00100, 8'hAB, 1'b1, 0, cyc, rd, weL, oeL, aAcc, ubA, lbA, dqD);
        checkOutput("wrLanes", {30'd0, ubA, lbA}, 32'h2);
        checkOutput("wrDq", {16'd0, dqD}, 32'hABAB);
        checkOutput("wrAddr", {13'd0, aAcc}, 32'h00080);
        checkOutput("wrWeWidth", weL, 3);
        checkOutput("wrNoOe", oeL, 0);
        checkOutput("wrCycles", cyc, 5);
        applyStimulus(0, 20'h00100, 8'h00, 1'b0, 0, cyc, rd, weL, oeL, aAcc, ubA, lbA, dqD);
        checkOutput("wrThenHitBus", {24'd0, rd}, 32'hAB);
        checkOutput("wrThenHitCycles", cyc, 2);

        $display("[TB] write to uncached word");
        applyStimulus(0, 20'h30003, 8'h55, 1'b1, 0, cyc, rd, weL, oeL, aAcc, ubA, lbA, dqD);
        checkOutput("wrMissLanes", {30'd0, ubA, lbA}, 32'h1);
        checkOutput("wrMissCycles", cyc, 5);
        applyStimulus(0, 20'h00101, 8'h00, 1'b0, 0, cyc, rd, weL, oeL, aAcc, ubA, lbA, dqD);
        checkOutput("tagKeptBus", {24'd0, rd}, 32'h34);
        checkOutput("tagKeptCycles", cyc, 2);
        sramRd = 16'h55C3;
        applyStimulus(0, 20'h30003, 8'h00, 1'b0, 0, cyc, rd, weL, oeL, aAcc, ubA, lbA, dqD);
        checkOutput("rdAfterWrBus", {24'd0, rd}, 32'h55);
        checkOutput("rdAfterWrCycles", cyc, 5);

        $display("[TB] inputs changing during access");
        sramRd = 16'h9A78;
        applyStimulus(0, 20'h4000A, 8'h00, 1'b0, 1, cyc, rd, weL, oeL, aAcc, ubA, lbA, dqD);
        checkOutput("scrAddr", {13'd0, aAcc}, 32'h20005);
        checkOutput("scrLanes", {30'd0, ubA, lbA}, 32'h2);
        checkOutput("scrBus", {24'd0, rd}, 32'h78);
        checkOutput("scrNoWe", weL, 0);
        checkOutput("scrOeWidth", oeL, 3);
        checkOutput("scrCycles", cyc, 5);

        $display("[TB] WAIT=0 back-to-back misses");
        resetF = 1'b0;
        sramRd = 16'h1111;
        applyStimulus(1, 20'h10000, 8'h00, 1'b0, 0, cyc, rd, weL, oeL, aAcc, ubA, lbA, dqD);
        checkOutput("fast1Bus", {24'd0, rd}, 32'h11);
        checkOutput("fast1Cycles", cyc, 3);
        checkOutput("fast1OeWidth", oeL, 1);
        sramRd = 16'h2222;
        applyStimulus(1, 20'h20000, 8'h00, 1'b0, 0, cyc, rd, weL, oeL, aAcc, ubA, lbA, dqD);
        checkOutput("fast2Bus", {24'd0, rd}, 32'h22);
        checkOutput("fast2Cycles", cyc, 3);
        checkOutput("fastMinGap", minGapF, 2);
        resetF = 1'b1;

        checkOutput("noWeOeOverlap", bothLowS, 0);
        checkOutput("noDoubleLocked", doubleLock, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/core88_memctl.md
# core88_memctl

Memory controller directly downstream of the 8088-compatible core. It turns the core's one-byte-per-step bus (`address`, `data`, `wreq`, `bus`) into accesses on a 16-bit asynchronous SRAM with programmable wait states. It paces the core through its `locked` enable: every core step costs one completed memory transaction. A one-word read cache lets repeated reads from the same 16-bit word finish without SRAM wait states.

## Interface
- `WAIT`, default 2: extra SRAM access cycles per miss or write, range 0..15.
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  20  core byte address. Stable whenever `locked`=0.
- `data`  in  8  core write byte.
- `wreq`  in  1  core write request; 1 = write, 0 = read.
- `bus`  out  8  read byte returned to the core. Valid in the cycle `locked`=1.
- `locked`  out  1  core advance enable; high for exactly one cycle per transaction.
- `sram_a`  out  19  SRAM word address, equal to `address[19:1]`.
- `sram_dq_o`  out  16  SRAM write data, `{data,data}`.
- `sram_dq_i`  in  16  SRAM read data.
- `sram_we_n`, `sram_oe_n`  out  1 each  active-low write and output enables.
- `sram_ub_n`, `sram_lb_n`  out  1 each  active-low byte lanes. Odd address selects the upper byte; even address selects the lower byte.

## Operation
- Registered state: `st` ∈ {SAMPLE, ACCESS, DONE}, a 4-bit counter `cnt`, latched `a_r[19:0]`, `d_r`, `w_r`, and the cache (`c_valid`, `c_tag[18:0]`, `c_word[15:0]`).
- Hit condition: `c_valid` && `c_tag == address[19:1]`.
- SAMPLE (`locked`=0):
  - Latch `address`, `data` and `wreq`.
  - Read hit: `bus` <= the selected byte of `c_word`. Go to DONE with no SRAM cycle.
  - Read miss: drive `sram_a`, set `sram_oe_n`=0 and the lane enables, `cnt`<=WAIT, go to ACCESS.
  - Write: drive `sram_a` and `sram_dq_o`, set `sram_we_n`=0 and the lane enables, `cnt`<=WAIT, go to ACCESS.
- ACCESS: SRAM controls are held.
  - If `cnt`≠0: `cnt`<=`cnt`-1 and stay in ACCESS.
  - If `cnt`=0 on a read: `bus` <= the selected byte of `sram_dq_i`; `c_word` <= `sram_dq_i`, `c_tag` <= `a_r[19:1]`, `c_valid` <= 1.
  - If `cnt`=0 on a write that hits the cache: the written byte lane of `c_word` is updated (write-through). A write that misses leaves the cache unchanged.
  - After `cnt`=0, release the enables (`we_n`/`oe_n`/lanes = 1) and go to DONE.
- DONE: `locked`=1 for this single cycle, then go to SAMPLE. The core latches `bus` and advances on this edge.
- Byte selection: `a_r[0]`=1 selects `[15:8]`; `a_r[0]`=0 selects `[7:0]`.
- `sram_a` and `sram_dq_o` hold their value through DONE. `sram_we_n` is already 1 in DONE, so address hold time is met.
- The write path never raises `oe_n` and `we_n` low together.

## Timing
- Reset values:
  - `st`=SAMPLE, `locked`=0, `bus`=8'h00, `cnt`=0.
  - `sram_we_n`, `sram_oe_n`, `sram_ub_n`, `sram_lb_n` = 1; `sram_a`=0; `sram_dq_o`=0.
  - `c_valid`=0.
- Reset takes effect immediately, including mid-ACCESS. The SRAM enables deassert asynchronously and no `locked` pulse is issued. The first transaction after release starts in SAMPLE on the next edge.
- Transaction length in clocks, counted from SAMPLE entry to the end of the `locked` cycle:
  - Read hit: 2 (SAMPLE, DONE).
  - Read miss or any write: WAIT+3 (SAMPLE, WAIT+1 ACCESS, DONE).
  - With WAIT=0, ACCESS lasts one cycle.
- `locked` is never high in two consecutive cycles, and `locked`=1 always implies `st`=DONE.
- `sram_we_n` low width is exactly WAIT+1 cycles. `sram_oe_n` low width is exactly WAIT+1 cycles.
- Inputs are sampled only in SAMPLE. Changes to `address`, `data` or `wreq` during ACCESS or DONE are ignored.
- A write followed by a read of the same byte returns the new value, whether that read hits or misses.

## Test plan
- Reset asserted mid-ACCESS on a write:
  - `sram_we_n` returns to 1 in the same cycle and `locked` stays 0.
  - After release, a read of 0xFFFF0 with `sram_dq_i`=16'hEAxx returns `bus`=8'hxx with `locked` in cycle 5 (WAIT=2).
- Read miss at 0x00101 with `sram_dq_i`=16'h3412, then a read of 0x00100:
  - First read returns `bus`=8'h34 in 5 clocks.
  - Second read hits, returns 8'h12 in 2 clocks, and `sram_oe_n` stays 1.
- Write 8'hAB to 0x00100 (cached word), then read 0x00100:
  - `sram_lb_n`=0, `sram_ub_n`=1, `sram_dq_o`=16'hABAB, `we_n` low for 3 cycles.
  - The read hits and returns 8'hAB.
- Write 8'h55 to an uncached word:
  - The cache tag is unchanged.
  - A following read of that byte misses and returns the SRAM value after 5 clocks.
- WAIT=0, back-to-back misses 0x10000 and 0x20000:
  - Each returns `locked` after 3 clocks.
  - `locked` pulses are separated by at least 2 low cycles.
- Changing `address` and `wreq` during ACCESS:
  - `sram_a`, the lanes and the returned `bus` reflect only the SAMPLE-cycle values.
